// File: rtl/led_sample_scheduler.sv
// led_sample_scheduler
// Time-multiplexes a RED and an IR LED for a pulse-oximeter style front end.
// Each frame is RED_ON, GAP_A, IR_ON, GAP_B. The analog front-end settings
// (DC compensation, PGA gain) follow the active LED, and one ADC sample is
// captured per LED phase once the optics have settled. Configuration inputs
// are shadowed at the start of every frame so that a frame is always
// self-consistent, even if software rewrites the inputs mid-frame.
module led_sample_scheduler #(
  parameter int SETTLE_CYCLES = 4,
  parameter int PHASE_CYCLES  = 10,
  parameter int GAP_CYCLES    = 5
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [6:0] RED_DC_Comp,
  input  logic [6:0] IR_DC_Comp,
  input  logic [3:0] RED_PGA,
  input  logic [3:0] IR_PGA,
  input  logic [7:0] ADC,
  output logic       LED_RED,
  output logic       LED_IR,
  output logic [6:0] DC_Comp,
  output logic [3:0] PGA_Gain,
  output logic [7:0] RED_ADC_Value,
  output logic [7:0] IR_ADC_Value,
  output logic       sample_valid,
  output logic [7:0] frame_count,
  output logic       busy
);

  localparam int MAX_CYCLES = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] SETTLE_AT  = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [6:0]       DC_RESET   = 7'd64;

  typedef enum logic [2:0] {
    IDLE,
    RED_ON,
    GAP_A,
    IR_ON,
    GAP_B
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Goes high on the first edge after reset release; a frame may only start
  // once it is set, so nothing moves on the very first edge out of reset.
  logic             start_ok;

  logic [6:0]       red_dc_sh;
  logic [6:0]       ir_dc_sh;
  logic [3:0]       red_pga_sh;
  logic [3:0]       ir_pga_sh;

  // Frame sequencer: state, phase counter, shadow registers and all outputs.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      start_ok      <= 1'b0;
      red_dc_sh     <= DC_RESET;
      ir_dc_sh      <= DC_RESET;
      red_pga_sh    <= 4'd0;
      ir_pga_sh     <= 4'd0;
      LED_RED       <= 1'b0;
      LED_IR        <= 1'b0;
      DC_Comp       <= DC_RESET;
      PGA_Gain      <= 4'd0;
      RED_ADC_Value <= 8'd0;
      IR_ADC_Value  <= 8'd0;
      sample_valid  <= 1'b0;
      frame_count   <= 8'd0;
      busy          <= 1'b0;
    end else begin
      start_ok     <= 1'b1;
      sample_valid <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (enable && start_ok) begin
            state      <= RED_ON;
            red_dc_sh  <= RED_DC_Comp;
            ir_dc_sh   <= IR_DC_Comp;
            red_pga_sh <= RED_PGA;
            ir_pga_sh  <= IR_PGA;
            LED_RED    <= 1'b1;
            LED_IR     <= 1'b0;
            DC_Comp    <= RED_DC_Comp;
            PGA_Gain   <= RED_PGA;
            busy       <= 1'b1;
          end
        end

        RED_ON: begin
          DC_Comp  <= red_dc_sh;
          PGA_Gain <= red_pga_sh;
          if (cnt == SETTLE_AT) begin
            RED_ADC_Value <= ADC;
          end
          if (cnt == PHASE_LAST) begin
            state   <= GAP_A;
            cnt     <= '0;
            LED_RED <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        GAP_A: begin
          if (cnt == GAP_LAST) begin
            state    <= IR_ON;
            cnt      <= '0;
            LED_IR   <= 1'b1;
            DC_Comp  <= ir_dc_sh;
            PGA_Gain <= ir_pga_sh;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        IR_ON: begin
          DC_Comp  <= ir_dc_sh;
          PGA_Gain <= ir_pga_sh;
          if (cnt == SETTLE_AT) begin
            IR_ADC_Value <= ADC;
            sample_valid <= 1'b1;
            frame_count  <= frame_count + 8'd1;
          end
          if (cnt == PHASE_LAST) begin
            state  <= GAP_B;
            cnt    <= '0;
            LED_IR <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        GAP_B: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (enable) begin
              state      <= RED_ON;
              red_dc_sh  <= RED_DC_Comp;
              ir_dc_sh   <= IR_DC_Comp;
              red_pga_sh <= RED_PGA;
              ir_pga_sh  <= IR_PGA;
              LED_RED    <= 1'b1;
              DC_Comp    <= RED_DC_Comp;
              PGA_Gain   <= RED_PGA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          cnt     <= '0;
          LED_RED <= 1'b0;
          LED_IR  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
